// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: read-return FIFO between the BRAM controller and the CPU.
// It tracks reads still in flight so that credit_ok never admits more than the FIFO can absorb.
module bram_rd_fifo #(
   parameter int DW = 32,
   parameter int AW = 4,
   parameter int OW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd_issue,
   input  logic          fifo_in_valid,
   input  logic [DW-1:0] fifo_in_data,
   input  logic          cpu_req,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_data,
   output logic          credit_ok,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic [OW-1:0] outstanding,
   output logic          overflow
);
   localparam int D = 2**AW;
   logic [DW-1:0] mem [D];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, push, inc, dec;
   logic [AW+1:0] load;
   assign empty     = count == '0;
   assign full      = count == (AW+1)'(D);
   assign pop       = cpu_req & ~empty & ~cpu_ack;
   assign push      = fifo_in_valid & (~full | pop);
   // A simultaneous issue and return cancel out, even when the counter is saturated.
   assign inc       = rd_issue & ~fifo_in_valid & (outstanding != OW'(D));
   assign dec       = fifo_in_valid & ~rd_issue & (outstanding != '0);
   assign load      = (AW+2)'(count) + (AW+2)'(outstanding);
   assign credit_ok = load < (AW+2)'(D);
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= fifo_in_data;
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         overflow    <= 1'b0;
         cpu_ack     <= 1'b0;
         cpu_data    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (pop) cpu_data <= mem[rd_ptr];
         cpu_ack     <= pop;
         count       <= count + (AW+1)'(push) - (AW+1)'(pop);
         outstanding <= outstanding + OW'(inc) - OW'(dec);
         overflow    <= overflow | (fifo_in_valid & ~push);
      end
endmodule

// File: tb/tb_bram_rd_fifo.sv
// tb_bram_rd_fifo: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the read-return FIFO.
module tb_bram_rd_fifo;
   localparam int DW = 32, AW = 4, OW = 5, D = 16;
   logic          clk = 1'b0, rst_n = 1'b0, rd_issue = 1'b0, fifo_in_valid = 1'b0, cpu_req = 1'b0;
   logic [DW-1:0] fifo_in_data = '0;
   logic          cpu_ack, credit_ok, empty, full, overflow;
   logic [DW-1:0] cpu_data;
   logic [AW:0]   count;
   logic [OW-1:0] outstanding;
   int            errors = 0, checks = 0;
   logic [31:0]   q[$];
   logic [31:0]   got[$];
   int            mo;
   bit            mov, mack;
   logic [31:0]   mdata;
   typedef struct {
      bit ri, fv, req;
      logic [31:0] fd;
      int n, cnt, outs;
      bit ack;
      logic [31:0] data;
   } vec_t;
   vec_t tv[11];

   bram_rd_fifo #(.DW(DW), .AW(AW), .OW(OW)) dut (
      .clk(clk), .rst_n(rst_n), .rd_issue(rd_issue), .fifo_in_valid(fifo_in_valid),
      .fifo_in_data(fifo_in_data), .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
      .credit_ok(credit_ok), .empty(empty), .full(full), .count(count),
      .outstanding(outstanding), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("cpu_ack", 32'(cpu_ack), 32'(mack));
      chk("cpu_data", cpu_data, mdata);
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == D));
      chk("outstanding", 32'(outstanding), 32'(mo));
      chk("credit_ok", 32'(credit_ok), 32'((q.size() + mo) < D));
      chk("overflow", 32'(overflow), 32'(mov));
   endtask

   // Model decides this edge's pop/push from the pre-edge state, then compares after the edge.
   task automatic cyc(input bit ri, input bit fv, input logic [31:0] fd, input bit req);
      bit pop, push;
      rd_issue = ri; fifo_in_valid = fv; fifo_in_data = fd; cpu_req = req;
      pop  = req && q.size() > 0 && !mack;
      push = fv && (q.size() < D || pop);
      mack = pop;
      if (pop) mdata = q.pop_front();
      if (push) q.push_back(fd);
      if (fv && !push) mov = 1'b1;
      if (ri && !fv && mo < D) mo++;
      else if (fv && !ri && mo > 0) mo--;
      @(posedge clk); #1;
      chk_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; rd_issue = 1'b0; fifo_in_valid = 1'b0; cpu_req = 1'b0;
      q.delete(); mo = 0; mov = 1'b0; mack = 1'b0; mdata = '0;
      @(posedge clk); #1;
      chk_all();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      got.delete();
      while (!empty && n < 100) begin
         cyc(0, 0, 0, 1);
         if (cpu_ack) got.push_back(cpu_data);
         n++;
      end
      cyc(0, 0, 0, 0);
      chk("drain_bound", 32'(empty), 32'(1));
   endtask

   initial begin
      tv = '{
         '{1, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0},
         '{1, 0, 0, 32'h0,  1, 0, 2, 0, 32'h0},
         '{1, 0, 0, 32'h0,  1, 0, 3, 0, 32'h0},
         '{0, 0, 1, 32'h0, 10, 0, 3, 0, 32'h0},
         '{0, 1, 1, 32'hA0, 1, 1, 2, 0, 32'h0},
         '{0, 1, 1, 32'hA1, 1, 1, 1, 1, 32'hA0},
         '{0, 1, 1, 32'hA2, 1, 2, 0, 0, 32'hA0},
         '{0, 0, 1, 32'h0,  1, 1, 0, 1, 32'hA1},
         '{0, 0, 1, 32'h0,  1, 1, 0, 0, 32'hA1},
         '{0, 0, 1, 32'h0,  1, 0, 0, 1, 32'hA2},
         '{0, 0, 0, 32'h0,  1, 0, 0, 0, 32'hA2}
      };
      do_reset();
      repeat (5) cyc(0, 0, 0, 0);
      chk("idle_empty", 32'(empty), 32'(1));
      chk("idle_credit", 32'(credit_ok), 32'(1));
      for (int i = 0; i < 11; i++) begin
         for (int k = 0; k < tv[i].n; k++) cyc(tv[i].ri, tv[i].fv, tv[i].fd, tv[i].req);
         chk("tv_count", 32'(count), 32'(tv[i].cnt));
         chk("tv_outstanding", 32'(outstanding), 32'(tv[i].outs));
         chk("tv_ack", 32'(cpu_ack), 32'(tv[i].ack));
         chk("tv_data", cpu_data, tv[i].data);
      end
      chk("tv_end_empty", 32'(empty), 32'(1));
      // credit exhaustion, saturation and recovery after one pop
      do_reset();
      repeat (16) cyc(1, 0, 0, 0);
      chk("credit_after16", 32'(credit_ok), 32'(0));
      cyc(1, 0, 0, 0);
      chk("outstanding_sat", 32'(outstanding), 32'(16));
      for (int i = 0; i < 16; i++) cyc(0, 1, 32'h100 + 32'(i), 0);
      chk("fill_full", 32'(full), 32'(1));
      chk("fill_count", 32'(count), 32'(16));
      chk("fill_credit", 32'(credit_ok), 32'(0));
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk("pop_count", 32'(count), 32'(15));
      chk("pop_credit", 32'(credit_ok), 32'(1));
      // overflow on a full FIFO without pop
      cyc(0, 1, 32'h1FF, 0);
      cyc(0, 1, 32'hDEAD, 0);
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_count", 32'(count), 32'(16));
      drain();
      chk("ovf_drain_len", 32'(got.size()), 32'(16));
      foreach (got[i]) chk("ovf_no_dead", 32'(got[i] == 32'hDEAD), 32'(0));
      chk("ovf_sticky", 32'(overflow), 32'(1));
      do_reset();
      chk("ovf_cleared", 32'(overflow), 32'(0));
      // push into a full FIFO on the same edge as a pop
      for (int i = 0; i < 16; i++) cyc(0, 1, 32'h200 + 32'(i), 0);
      cyc(0, 1, 32'hBEEF, 1);
      chk("pp_count", 32'(count), 32'(16));
      chk("pp_overflow", 32'(overflow), 32'(0));
      drain();
      chk("pp_len", 32'(got.size()), 32'(16));
      chk("pp_last", got[got.size()-1], 32'hBEEF);
      for (int i = 0; i < 40; i++) cyc(0, i[0] == 1'b0, 32'h300 + 32'(i), 1);
      drain();
      // random traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0);
      drain();
      // reset in the middle of traffic
      do_reset();
      repeat (7) cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 32'h400 + 32'(i), 0);
      chk("mid_count", 32'(count), 32'(5));
      chk("mid_outstanding", 32'(outstanding), 32'(2));
      do_reset();
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_outstanding", 32'(outstanding), 32'(0));
      chk("rst_credit", 32'(credit_ok), 32'(1));
      chk("rst_data", cpu_data, 32'h0);
      cyc(0, 1, 32'h55, 0);
      chk("post_count", 32'(count), 32'(1));
      chk("post_outstanding", 32'(outstanding), 32'(0));
      cyc(0, 0, 0, 1);
      chk("post_ack", 32'(cpu_ack), 32'(1));
      chk("post_data", cpu_data, 32'h55);
      cyc(0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bram_rd_fifo.md
Name: bram_rd_fifo

Overview:
- Receive-side endpoint of the BRAM controller's read-return interface. Captures every `fifo_in_valid`/`Do` beat, since the controller has no backpressure, and returns the words in order to the CPU over a single-beat req/ack handshake.
- Tracks reads the arbiter has issued but BRAM has not yet returned (BRAM latency is 10 T). Exports a credit signal so the arbiter never issues a read the FIFO could not absorb.
- Sits between the BRAM controller output and the CPU-side Wishbone glue.

Parameters:
- DW, 32, data width; matches the controller `Do`.
- AW, 4, pointer width; depth = 2**AW = 16 entries.
- OW, 5, outstanding-counter width; must hold 0..2**AW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- rd_issue  in  1  one-cycle pulse from the arbiter; a valid BRAM read was issued this cycle.
- fifo_in_valid  in  1  push strobe from the BRAM controller.
- fifo_in_data  in  DW  push data (controller `Do`).
- cpu_req  in  1  CPU read request; level, held until `cpu_ack`.
- cpu_ack  out  1  one-cycle acknowledge; `cpu_data` is valid while high.
- cpu_data  out  DW  popped word, registered.
- credit_ok  out  1  arbiter may issue one more read this cycle.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == 2**AW.
- count  out  AW+1  current occupancy.
- outstanding  out  OW  reads issued and not yet returned.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low at a clk edge): pointers, count, outstanding, overflow and cpu_ack all go to 0; cpu_data goes to 0; empty=1, full=0, credit_ok=1. Storage contents are don't-care.
- Reset mid-operation discards all queued and in-flight bookkeeping. Beats arriving afterwards are pushed as fresh data, and outstanding saturates at 0.

Push:
- Push when fifo_in_valid=1 and (full=0 or a pop occurs the same edge).
- Write data at wr_ptr, then wr_ptr+1, wrapping 2**AW-1 -> 0.
- When fifo_in_valid=1, full=1 and there is no pop: data is dropped, overflow is set and stays set until reset, and count is unchanged.

Pop:
- Pop when cpu_req=1, empty=0 and cpu_ack=0 (current registered value).
- On the next edge: cpu_data <= mem[rd_ptr], rd_ptr+1 with wrap, cpu_ack <= 1.
- cpu_ack is high for exactly one cycle, then low for at least one cycle, so back-to-back pops run at most every 2 cycles.
- If cpu_req drops before it is serviced, no pop occurs.
- cpu_data holds its last value while cpu_ack=0.
- Latency: a push at edge N makes empty=0 after N. A cpu_req already high yields cpu_ack at edge N+1.
- No bypass: a push and a pop attempt on an empty FIFO in the same cycle means the pop waits.

Count and flags:
- count is +1 on push only, -1 on pop only, unchanged on both or neither.
- full and empty are derived combinationally from count.

Outstanding:
- +1 on rd_issue, -1 on fifo_in_valid.
- Both in the same cycle: unchanged.
- fifo_in_valid with outstanding=0 (e.g. pre-store write echoes from the controller): stays 0, and the data is still pushed.
- Saturates at 2**AW; rd_issue beyond that is ignored for counting.

Credit:
- credit_ok = (count + outstanding) < 2**AW, combinational, using unsigned AW+2-bit arithmetic.
- A pop in flight does not add credit until count actually decrements.

Test Plan:
- Reset, then idle for 5 cycles -> empty=1, count=0, outstanding=0, credit_ok=1, cpu_ack=0, overflow=0.
- Pulse rd_issue 3 times, then 10 cycles later push 0xA0, 0xA1, 0xA2 on consecutive cycles, with cpu_req held high -> outstanding goes 1,2,3 then back to 0. cpu_ack pulses 3 times (every other cycle) with data 0xA0, 0xA1, 0xA2 in order; empty=1 at the end.
- Issue 16 reads with no cpu_req -> credit_ok=0 after the 16th issue. Return 16 pushes -> full=1, count=16, credit_ok=0. One pop -> credit_ok=1 and count=15.
- Full FIFO, push 0xDEAD with no pop -> overflow=1 and count stays 16. The drained sequence contains no 0xDEAD. overflow stays 1 until rst_n is low.
- Full FIFO, push 0xBEEF in the same cycle as a pop -> count stays 16, overflow=0, and 0xBEEF is the last word drained. Run 40 push/pop cycles to exercise pointer wrap with the data order preserved.
- Mid-stream with count=5 and outstanding=2, assert rst_n=0 for one cycle -> all outputs return to reset values. A subsequent push of 0x55 -> count=1, outstanding=0, and 0x55 is popped intact.
